// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions (state codes, frame width, helpers).
//                Usable by both the receiver and the transmitter.
//                The PARITY state exists only when UART_RX_PARITY_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_WAIT_HI = 3'd4;
  localparam logic [2:0] ST_PARITY  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_START   = ST_START,
    S_DATA    = ST_DATA,
    S_STOP    = ST_STOP,
`ifdef UART_RX_PARITY_EN
    S_WAIT_HI = ST_WAIT_HI,
    S_PARITY  = ST_PARITY
`else
    S_WAIT_HI = ST_WAIT_HI
`endif
  } uart_state_e;

  // Counter value at which the mid-start-bit sample is taken.
  function automatic int half_bit_last(input int clks_per_bit);
    return (clks_per_bit / 2) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Multi-flop synchronizer for the asynchronous serial line.
//                All stages are set to 1 (idle level) on reset so that reset
//                release can never look like a start bit.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  // First stage captures the raw line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_chain[0] <= 1'b1;
    else     r_chain[0] <= i_async;
  end

  // Remaining stages form a plain shift chain.
  for (genvar g = 1; g < SYNC_STAGES; g++) begin : g_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_chain[g] <= 1'b1;
      else     r_chain[g] <= r_chain[g-1];
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver, mid-bit sampling with an inline baud
//                counter. Delivers one byte per good frame with a one-cycle
//                rxdone strobe; bad stop bits give a one-cycle frame_err.
//                Optional macro UART_RX_PARITY_EN switches to 8E1 and adds
//                the parity_err output.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxsd,
  output logic [7:0] rxpd,
  output logic       rxdone,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic [2:0] state,
  output logic       parity_err
`else
  output logic [2:0] state
`endif
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
  localparam int c_idx_w = $clog2(DATA_BITS);
  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(half_bit_last(CLKS_PER_BIT));
  localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(DATA_BITS - 1);

  logic w_rx_s;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rxsd),
    .o_sync  (w_rx_s)
  );

  uart_state_e            r_state, w_state_nxt;
  logic [c_cnt_w-1:0]     r_cnt,   w_cnt_nxt;
  logic [c_idx_w-1:0]     r_idx,   w_idx_nxt;
  logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0]   r_rxpd,  w_rxpd_nxt;
  logic                   r_done,  w_done_nxt;
  logic                   r_ferr,  w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
  logic                   r_pbad,  w_pbad_nxt;
  logic                   r_perr,  w_perr_nxt;
`endif

  // State, counters, shift register and registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_rxpd  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pbad  <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_rxpd  <= w_rxpd_nxt;
      r_done  <= w_done_nxt;
      r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
      r_pbad  <= w_pbad_nxt;
      r_perr  <= w_perr_nxt;
`endif
    end
  end

  // Next-state, baud counting and sampling decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_rxpd_nxt  = r_rxpd;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_pbad_nxt  = r_pbad;
    w_perr_nxt  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == c_half_last) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          // A line already back high at mid-start was only a glitch.
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == c_cnt_last) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
          if (r_idx == c_idx_last) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == c_cnt_last) begin
          w_cnt_nxt   = '0;
          // Even parity: data plus parity bit must XOR to zero.
          w_pbad_nxt  = ^{r_shift, w_rx_s};
          w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (r_cnt == c_cnt_last) begin
          w_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
          w_perr_nxt = r_pbad;
`endif
          if (w_rx_s) begin
`ifdef UART_RX_PARITY_EN
            if (!r_pbad) begin
              w_rxpd_nxt = r_shift;
              w_done_nxt = 1'b1;
            end
`else
            w_rxpd_nxt = r_shift;
            w_done_nxt = 1'b1;
`endif
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_WAIT_HI;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WAIT_HI: begin
        // Hold off until the line returns idle so a break cannot retrigger.
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign rxpd      = r_rxpd;
  assign rxdone    = r_done;
  assign frame_err = r_ferr;
  assign state     = r_state;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx (CLKS_PER_BIT=16,
//                SYNC_STAGES=2). Parity cases run when UART_RX_PARITY_EN is
//                defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int c_lat = SYNC + FRAME_BITS * CPB - CPB / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxsd;
  logic [7:0] rxpd;
  logic       rxdone;
  logic       frame_err;
  logic [2:0] state;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxsd       (rxsd),
    .rxpd       (rxpd),
    .rxdone     (rxdone),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .state      (state),
    .parity_err (parity_err)
`else
    .state      (state)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitors, sampled on the falling edge.
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         perr_cnt = 0;
  int         done_cyc[$];
  logic [7:0] done_val[$];
  always @(negedge clk) begin
    if (rxdone === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc.push_back(cyc);
      done_val.push_back(rxpd);
    end
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (rxdone === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) perr_cnt <= perr_cnt + 1;
`endif
  end

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;
  int start_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive n frame bits, bit 0 first, one bit period each; call on a negedge.
  task automatic send_raw(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 0) start_cyc = cyc;
      rxsd = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [10:0] f;
`ifdef UART_RX_PARITY_EN
    f = {stop, ^b, b, 1'b0};
`else
    f = {1'b0, stop, b, 1'b0};
`endif
    send_raw(f, FRAME_BITS);
  endtask

  task automatic idle(input int n);
    rxsd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int d0, f0, lat, gap;

  initial begin
    rst  = 1'b1;
    rxsd = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rxpd",   {24'd0, rxpd},      32'h00);
    chk("reset_rxdone", {31'd0, rxdone},    32'h0);
    chk("reset_ferr",   {31'd0, frame_err}, 32'h0);
    chk("reset_state",  {29'd0, state},     32'h0);
    rst = 1'b0;
    idle(5);

    // Clean frame 0xA5.
    d0 = done_cnt; f0 = ferr_cnt;
    send_byte(8'hA5, 1'b1);
    idle(20);
    chk("a5_done_cnt", done_cnt - d0,       32'd1);
    chk("a5_rxpd",     {24'd0, rxpd},       32'hA5);
    chk("a5_ferr_cnt", ferr_cnt - f0,       32'd0);
    chk("a5_state",    {29'd0, state},      32'h0);
    lat = done_cyc[done_cyc.size()-1] - start_cyc;
    chk("a5_latency_in_window", {31'd0, (lat >= c_lat - 2 && lat <= c_lat + 2)}, 32'd1);

    // Back-to-back 0x00 then 0xFF, no idle gap.
    d0 = done_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(20);
    chk("b2b_done_cnt", done_cnt - d0, 32'd2);
    chk("b2b_first",  {24'd0, done_val[done_val.size()-2]}, 32'h00);
    chk("b2b_second", {24'd0, done_val[done_val.size()-1]}, 32'hFF);
    gap = done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2];
    chk("b2b_spacing_in_window",
        {31'd0, (gap >= FRAME_BITS * CPB - 2 && gap <= FRAME_BITS * CPB + 2)}, 32'd1);

    // Glitch: low for 5 clk then high.
    d0 = done_cnt; f0 = ferr_cnt;
    rxsd = 1'b0;
    repeat (3) @(negedge clk);
    chk("glitch_state_start", {29'd0, state}, 32'h1);
    repeat (2) @(negedge clk);
    idle(20);
    chk("glitch_state_idle", {29'd0, state},  32'h0);
    chk("glitch_no_done",    done_cnt - d0,   32'd0);
    chk("glitch_no_ferr",    ferr_cnt - f0,   32'd0);
    chk("glitch_rxpd_kept",  {24'd0, rxpd},   32'hFF);

    // 0x3C with a low stop bit, line held low 40 more clk.
    d0 = done_cnt; f0 = ferr_cnt;
    send_byte(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    chk("ferr_pulse_cnt",  ferr_cnt - f0,  32'd1);
    chk("ferr_no_done",    done_cnt - d0,  32'd0);
    chk("ferr_rxpd_kept",  {24'd0, rxpd},  32'hFF);
    chk("ferr_wait_hi",    {29'd0, state}, 32'h4);
    idle(20);
    chk("ferr_back_idle",  {29'd0, state}, 32'h0);
    send_byte(8'h55, 1'b1);
    idle(20);
    chk("after_ferr_done", done_cnt - d0,  32'd1);
    chk("after_ferr_rxpd", {24'd0, rxpd},  32'h55);

    // Reset in the middle of data bit 4 of 0x81.
    d0 = done_cnt;
    send_raw({2'b11, 8'h81, 1'b0}, 5);
    rxsd = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_rxpd",  {24'd0, rxpd},  32'h00);
    chk("midrst_state", {29'd0, state}, 32'h0);
    chk("midrst_done",  {31'd0, rxdone}, 32'h0);
    @(negedge clk);
    rxsd = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(CPB * 6);
    chk("midrst_no_done", done_cnt - d0, 32'd0);
    send_byte(8'h81, 1'b1);
    idle(20);
    chk("after_rst_done", done_cnt - d0, 32'd1);
    chk("after_rst_rxpd", {24'd0, rxpd}, 32'h81);

`ifdef UART_RX_PARITY_EN
    // Good even parity for 0x07 is 1; then the same byte with it flipped.
    d0 = done_cnt; f0 = perr_cnt;
    send_raw({1'b1, 1'b1, 8'h07, 1'b0}, 11);
    idle(20);
    chk("par_ok_done", done_cnt - d0, 32'd1);
    chk("par_ok_rxpd", {24'd0, rxpd}, 32'h07);
    chk("par_ok_perr", perr_cnt - f0, 32'd0);
    send_byte(8'h00, 1'b1);
    idle(20);
    d0 = done_cnt; f0 = perr_cnt;
    send_raw({1'b1, 1'b0, 8'h07, 1'b0}, 11);
    idle(20);
    chk("par_bad_perr", perr_cnt - f0, 32'd1);
    chk("par_bad_done", done_cnt - d0, 32'd0);
    chk("par_bad_rxpd", {24'd0, rxpd}, 32'h00);
`endif

    chk("never_done_and_ferr", both_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: observed still running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Samples the asynchronous serial line `rxsd` with the system clock `clk` and delivers one parallel byte per frame, with a one-cycle valid strobe.
- It is the receive counterpart of the team's UART transmitter: LSB first, low start bit, high stop bit, idle line high.
- Sits between the board RX pin and the byte consumer (loopback checker / command decoder).

Parameters:
- CLKS_PER_BIT, 10416: `clk` cycles per bit period (100 MHz / 9600 baud). Must be >= 4.
- SYNC_STAGES, 2: number of synchronizer flops on `rxsd`. Must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- rxsd  input  1  serial line, asynchronous to `clk`, idle high.
- rxpd  output  8  last correctly received byte; holds its value until the next good frame.
- rxdone  output  1  one-cycle pulse when `rxpd` is updated.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- state  output  3  current FSM state, for debug/LED.

Behaviour:
- Reset:
  - The FSM goes to IDLE and the baud counter and bit index clear.
  - rxpd=8'h00, rxdone=0, frame_err=0, state=IDLE.
  - All synchronizer flops reset to 1, so reset never produces a false start bit.
  - Reset mid-frame abandons the frame silently: no rxdone, no frame_err.
- Synchronizer: `rxsd` passes through SYNC_STAGES flops; call the result `rx_s`. All sampling uses `rx_s` only.
- State encoding (package constants): IDLE=0, START=1, DATA=2, STOP=3, WAIT_HI=4, PARITY=5 (PARITY only with the optional feature).
- IDLE: when rx_s==0, clear the counter and go to START.
- START: count to CLKS_PER_BIT/2 - 1 (integer division), then sample the mid start bit.
  - rx_s==0: clear the counter and bit index, go to DATA.
  - rx_s==1: glitch; return to IDLE with no outputs.
- DATA: every CLKS_PER_BIT cycles (counter wraps at CLKS_PER_BIT-1), sample rx_s at mid-bit.
  - Shift it into the shift register MSB side, right-shifting, so bit 0 arrives first.
  - After the 8th sample (index 7), go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - 1: on the next cycle rxpd <= shift register and rxdone=1 for exactly one cycle; go to IDLE.
  - 0: frame_err=1 for one cycle, rxpd unchanged; go to WAIT_HI.
- WAIT_HI: stay until rx_s==1, then go to IDLE. This prevents a break condition from retriggering frames.
- Latency: rxdone rises SYNC_STAGES + 9.5×CLKS_PER_BIT (±2) clk cycles after the start-bit falling edge on `rxsd`.
- Back-to-back frames: the next start bit may begin immediately after mid-stop; IDLE detects it with no gap required.
- rxdone and frame_err are never high in the same cycle.
- Counter width: $clog2(CLKS_PER_BIT) bits, unsigned, no overflow past CLKS_PER_BIT-1.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - The frame is 8E1. After DATA, the FSM goes to PARITY and samples one bit period later.
  - If XOR(data, parity bit) != 0, raise output parity_err (1 bit, one-cycle pulse) at the stop-sample point.
  - On parity error, rxpd is not updated and rxdone stays low. STOP handling is otherwise unchanged.
- Undefined: the PARITY state and the parity_err port do not exist; the frame is 8N1.

Decomposition:
- Package uart_pkg:
  - State constants (3-bit) and DATA_BITS=8.
  - Helper function for the half-bit count.
  - Shareable with the transmitter.
- Sub-module uart_rx_sync: SYNC_STAGES-deep flop chain with asynchronous set-to-1 on rst.
- The baud counter stays inline in uart_rx.

Test Plan (bench uses CLKS_PER_BIT=16, SYNC_STAGES=2):
- Send 8'hA5 as a clean 8N1 frame -> exactly one rxdone pulse, rxpd==8'hA5, frame_err never high, state returns to IDLE.
- Send 8'h00 then 8'hFF back-to-back with no idle gap -> two rxdone pulses 160±2 clk apart, rxpd==8'h00 then 8'hFF.
- Drive rxsd low for 5 clk then high (glitch) -> state goes START then IDLE, no rxdone, no frame_err, rxpd unchanged.
- Send 8'h3C with the stop bit low, holding rxsd low 40 more clk -> one frame_err pulse, rxpd keeps its previous value, state stays WAIT_HI until rxsd rises. A following frame 8'h55 is received correctly.
- Assert rst during DATA bit 4 of 8'h81 -> all outputs reset immediately, no rxdone. The next clean frame 8'h81 is received correctly.
- With UART_RX_PARITY_EN defined:
  - Send 8'h07 with a correct even-parity bit (1) -> rxdone, rxpd==8'h07.
  - Send it again with the parity bit flipped -> parity_err pulse, no rxdone.
